lsu_mem_port: RTL
=================

// Module: lsu_mem_port
// PURPOSE
//  Load/store port between the single-cycle datapath and a handshaked data memory.
//  Stores: aligns store data, drives byte strobes. Loads: returns the
//  sign/zero-extended result with its destination index to the register-file write port.
//  Sits between the ALU address output and the data-memory bus.
// PARAMETERS
//  Width    32   data/address width (only 32 supported)
//  TIMEOUT  16   max cycles from grant to mem_rvalid_i before err_o
// PORTS
//  clk_i          in   1      clock, rising edge
//  rst_ni         in   1      asynchronous reset, active low
//  req_valid_i    in   1      core issues load/store
//  req_ready_o    out  1      port can accept (high only in IDLE)
//  req_we_i       in   1      1=store, 0=load
//  req_size_i     in   2      00 byte, 01 half, 10 word, 11 illegal
//  req_unsigned_i in   1      load zero-extend (LBU/LHU)
//  req_addr_i     in   Width  byte address
//  req_wdata_i    in   Width  store data (low bytes significant)
//  req_rd_i       in   5      load destination register
//  mem_req_o      out  1      memory request, held until grant
//  mem_we_o       out  1      memory write
//  mem_addr_o     out  Width  word address {addr[31:2],2'b00}
//  mem_wdata_o    out  Width  lane-replicated store data
//  mem_be_o       out  4      byte strobes
//  mem_gnt_i      in   1      memory accepted request
//  mem_rvalid_i   in   1      response/ack (loads: rdata valid)
//  mem_rdata_i    in   Width  read word
//  wb_valid_o     out  1      one-cycle register-file write strobe
//  wb_rd_o        out  5      write index
//  wb_data_o      out  Width  extended load data
//  misalign_o     out  1      one-cycle pulse: misaligned/illegal request dropped
//  err_o          out  1      one-cycle pulse: response timeout
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 except req_ready_o=1; counter 0.
//  FSM IDLE->REQ->WAIT->IDLE:
//   IDLE: accept on req_valid_i; latch all req_* fields. Illegal size, half with addr[0]=1,
//    or word with addr[1:0]!=0 -> misalign_o=1 next cycle, stay IDLE, no memory access.
//   REQ: mem_req_o=1, addr/we/wdata/be stable until mem_gnt_i. On gnt -> WAIT, counter=0;
//    if gnt and rvalid arrive together, complete directly (same as WAIT+rvalid).
//   WAIT: count cycles; on mem_rvalid_i -> IDLE. Counter reaches TIMEOUT without rvalid ->
//    err_o pulse, IDLE, no writeback.
//  Writeback: registered, asserted the cycle after load rvalid, for one cycle.
//   wb_valid_o suppressed when rd==0 (x0 never written). Stores never assert wb_valid_o.
//  Best-case latency: accept t0, mem_req_o t1, gnt t1, rvalid t2, wb_valid_o t3.
//  Store align: byte be=4'b0001<<addr[1:0], wdata={4{d[7:0]}}; half be=4'b0011<<{addr[1],1'b0},
//   wdata={2{d[15:0]}}; word be=4'hF, wdata=d.
//  Load extract: byte=rdata>>(8*addr[1:0]) low 8; half=rdata>>(16*addr[1]) low 16;
//   sign-extend from bit 7/15 unless req_unsigned_i; word passes through.
//  mem_rvalid_i in IDLE or REQ without gnt: ignored. req_valid_i outside IDLE: ignored.
//  Reset asserted mid-transaction: immediate IDLE, pending request abandoned, no wb/err pulse.
// STRUCTURE
//  lsu_pkg: size enum (SZ_B, SZ_H, SZ_W), state enum (IDLE, REQ, WAIT), TIMEOUT width helper.
//  Sub-module lsu_align (combinational): store be/wdata generation and load extract/extend;
//   top holds FSM, request latches, timeout counter, wb registers.
// TESTING
//  1 SB addr 0x103, d=0x000000A5 -> be=4'b1000, wdata=0xA5A5A5A5, addr=0x100, no wb_valid_o.
//  2 LB addr 0x102, rdata=0x00800000, rd=5 -> wb_data=0xFFFFFF80, wb_rd=5; LBU -> 0x00000080.
//  3 LH addr 0x201 -> misalign_o one cycle, mem_req_o stays 0, req_ready_o stays 1.
//  4 LW, gnt delayed 3 cycles -> mem_req_o/addr stable for 3 cycles; gnt+rvalid same cycle -> wb next.
//  5 LW rd=0 rdata=0xDEADBEEF -> completes, wb_valid_o never asserted.
//  6 No rvalid for 16 cycles after gnt -> err_o pulse, back to IDLE; reset in WAIT -> all outputs 0.

Source files
------------

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types and sizing helpers for the load/store memory port
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    WAIT = 2'b10
  } state_e;

  localparam int LSU_TIMEOUT = 16;

  // Counter only has to hold 0..timeout-1 before the timeout fires.
  function automatic int cnt_width(input int timeout);
    return (timeout < 2) ? 1 : $clog2(timeout);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - store lane replication/byte strobes and load extract/extend
module lsu_align
  import lsu_pkg::*;
(
  input  size_e       size,
  input  logic [1:0]  addr_lo,
  input  logic        uns,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign byte_v = rdata[{addr_lo, 3'b000} +: 8];
  assign half_v = rdata[{addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    be        = 4'b0000;
    wdata_rep = '0;
    rdata_ext = '0;
    case (size)
      SZ_B: begin
        be        = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = {{24{~uns & byte_v[7]}}, byte_v};
      end
      SZ_H: begin
        be        = 4'b0011 << {addr_lo[1], 1'b0};
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = {{16{~uns & half_v[15]}}, half_v};
      end
      SZ_W: begin
        be        = 4'b1111;
        wdata_rep = wdata;
        rdata_ext = rdata;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_mem_port.sv
// rtl/lsu_mem_port.sv - load/store port between datapath and handshaked data memory
module lsu_mem_port
  import lsu_pkg::*;
#(
  parameter int Width   = 32,
  parameter int TIMEOUT = LSU_TIMEOUT
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_we_i,
  input  logic [1:0]       req_size_i,
  input  logic             req_unsigned_i,
  input  logic [Width-1:0] req_addr_i,
  input  logic [Width-1:0] req_wdata_i,
  input  logic [4:0]       req_rd_i,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic [Width-1:0] mem_addr_o,
  output logic [Width-1:0] mem_wdata_o,
  output logic [3:0]       mem_be_o,
  input  logic             mem_gnt_i,
  input  logic             mem_rvalid_i,
  input  logic [Width-1:0] mem_rdata_i,
  output logic             wb_valid_o,
  output logic [4:0]       wb_rd_o,
  output logic [Width-1:0] wb_data_o,
  output logic             misalign_o,
  output logic             err_o
);

  localparam int CW = cnt_width(TIMEOUT);

  state_e           state_q, state_d;
  logic             we_q, uns_q;
  size_e            size_q;
  logic [Width-1:0] addr_q, wdata_q;
  logic [4:0]       rd_q;
  logic [CW-1:0]    cnt_q;
  logic             wb_valid_q, misalign_q, err_q;
  logic [4:0]       wb_rd_q;
  logic [Width-1:0] wb_data_q;

  logic             req_bad, accept, done, timeout;
  logic [3:0]       be;
  logic [31:0]      wdata_rep, rdata_ext;

  always_comb begin
    req_bad = 1'b0;
    case (size_e'(req_size_i))
      SZ_B:    req_bad = 1'b0;
      SZ_H:    req_bad = req_addr_i[0];
      SZ_W:    req_bad = |req_addr_i[1:0];
      default: req_bad = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    done    = 1'b0;
    timeout = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          accept = 1'b1;
          if (!req_bad) state_d = REQ;
        end
      end
      REQ: begin
        if (mem_gnt_i) begin
          if (mem_rvalid_i) begin
            done    = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (mem_rvalid_i) begin
          done    = 1'b1;
          state_d = IDLE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          timeout = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= SZ_B;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= '0;
    end else if (accept) begin
      we_q    <= req_we_i;
      uns_q   <= req_unsigned_i;
      size_q  <= size_e'(req_size_i);
      addr_q  <= req_addr_i;
      wdata_q <= req_wdata_i;
      rd_q    <= req_rd_i;
    end
  end

  // Counter restarts every cycle spent in REQ so it is zero on the first WAIT cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)               cnt_q <= '0;
    else if (state_q == REQ)   cnt_q <= '0;
    else if (state_q == WAIT)  cnt_q <= cnt_q + CW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      misalign_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      wb_valid_q <= done & ~we_q & (rd_q != 5'd0);
      misalign_q <= accept & req_bad;
      err_q      <= timeout;
      if (done & ~we_q & (rd_q != 5'd0)) begin
        wb_rd_q   <= rd_q;
        wb_data_q <= rdata_ext;
      end
    end
  end

  lsu_align u_align (
    .size      (size_q),
    .addr_lo   (addr_q[1:0]),
    .uns       (uns_q),
    .wdata     (wdata_q),
    .rdata     (mem_rdata_i),
    .be        (be),
    .wdata_rep (wdata_rep),
    .rdata_ext (rdata_ext)
  );

  assign req_ready_o = (state_q == IDLE);
  assign mem_req_o   = (state_q == REQ);
  assign mem_we_o    = mem_req_o & we_q;
  assign mem_addr_o  = mem_req_o ? {addr_q[Width-1:2], 2'b00} : '0;
  assign mem_wdata_o = mem_req_o ? wdata_rep : '0;
  assign mem_be_o    = mem_req_o ? be : 4'b0000;
  assign wb_valid_o  = wb_valid_q;
  assign wb_rd_o     = wb_rd_q;
  assign wb_data_o   = wb_data_q;
  assign misalign_o  = misalign_q;
  assign err_o       = err_q;

endmodule
